// File: rtl/trace_buffer_instrucao.sv
// trace_buffer_instrucao
//   Instruction trace FIFO for the multicycle processor. Each rising edge of Done is one
//   completed instruction. When Enable is high, the block stores the record
//   {index, BusWires, Rx_data, Ry_data}. Records are popped one at a time with Next.
//   The output is first-word-fall-through: the head record is visible on Out_* while
//   Out_valid is high, and Out_* read 0 while the FIFO is empty.
// Ports
//   Clock, Resetn          : system clock, asynchronous active-low reset
//   Done                   : processor completion flag (level; edge-detected here)
//   BusWires/Rx_data/Ry_data: values captured on the Done rising edge
//   Enable                 : 1 = store records, 0 = only advance the instruction index
//   Next                   : one-cycle pop strobe
//   Clear                  : synchronous flush of pointers, level, index and overflow
//   Out_valid/Out_*        : head record
//   Level/Full/Empty       : occupancy (0..DEPTH)
//   Overflow               : sticky, set when a record was dropped on a full FIFO
module trace_buffer_instrucao #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Done,
  input  logic [DATA_W-1:0] BusWires,
  input  logic [DATA_W-1:0] Rx_data,
  input  logic [DATA_W-1:0] Ry_data,
  input  logic              Enable,
  input  logic              Next,
  input  logic              Clear,
  output logic              Out_valid,
  output logic [DATA_W-1:0] Out_index,
  output logic [DATA_W-1:0] Out_bus,
  output logic [DATA_W-1:0] Out_rx,
  output logic [DATA_W-1:0] Out_ry,
  output logic [ADDR_W:0]   Level,
  output logic              Full,
  output logic              Empty,
  output logic              Overflow
);

  localparam int unsigned RecW = 4 * DATA_W;
  localparam logic [ADDR_W:0]   LevelFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LevelOne  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PtrOne    = ADDR_W'(1);
  localparam logic [DATA_W-1:0] IdxOne    = DATA_W'(1);

  logic [RecW-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] idx_q, idx_d;
  logic              done_q;
  logic              ovf_q, ovf_d;

  logic capture, pop, push, drop, full, empty;
  logic [RecW-1:0] head_rec;

  assign full    = (level_q == LevelFull);
  assign empty   = (level_q == '0);
  assign capture = Done & ~done_q;
  assign pop     = Next & ~empty & ~Clear;
  // A full FIFO still accepts a push when a pop in the same cycle frees the head slot.
  assign push    = capture & Enable & (~full | pop) & ~Clear;
  assign drop    = capture & Enable & full & ~pop & ~Clear;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (Clear) begin
      head_d  = '0;
      tail_d  = '0;
      level_d = '0;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (capture) idx_d = idx_q + IdxOne;
      if (push)    tail_d = tail_q + PtrOne;
      if (pop)     head_d = head_q + PtrOne;
      if (push && !pop) level_d = level_q + LevelOne;
      if (pop && !push) level_d = level_q - LevelOne;
      if (drop)    ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      done_q  <= Done;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; validity is tracked by level_q.
  always_ff @(posedge Clock) begin
    if (push) mem_q[tail_q] <= {idx_q, BusWires, Rx_data, Ry_data};
  end

  always_comb begin
    head_rec = '0;
    if (!empty) head_rec = mem_q[head_q];
  end

  assign Out_valid = ~empty;
  assign Out_index = head_rec[4*DATA_W-1:3*DATA_W];
  assign Out_bus   = head_rec[3*DATA_W-1:2*DATA_W];
  assign Out_rx    = head_rec[2*DATA_W-1:DATA_W];
  assign Out_ry    = head_rec[DATA_W-1:0];
  assign Level     = level_q;
  assign Full      = full;
  assign Empty     = empty;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_trace_buffer_instrucao.sv
// Directed bench for trace_buffer_instrucao with hand-computed expectations.
module tb_trace_buffer_instrucao;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        Done, Enable, Next, Clear;
  logic [15:0] BusWires, Rx_data, Ry_data;
  logic        Out_valid, Full, Empty, Overflow;
  logic [15:0] Out_index, Out_bus, Out_rx, Out_ry;
  logic [3:0]  Level;

  int n_checks = 0;
  int n_errors = 0;

  trace_buffer_instrucao #(.DEPTH(8), .ADDR_W(3), .DATA_W(16)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .Done     (Done),
    .BusWires (BusWires),
    .Rx_data  (Rx_data),
    .Ry_data  (Ry_data),
    .Enable   (Enable),
    .Next     (Next),
    .Clear    (Clear),
    .Out_valid(Out_valid),
    .Out_index(Out_index),
    .Out_bus  (Out_bus),
    .Out_rx   (Out_rx),
    .Out_ry   (Out_ry),
    .Level    (Level),
    .Full     (Full),
    .Empty    (Empty),
    .Overflow (Overflow)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse(input logic [15:0] bus, input logic [15:0] rx, input logic [15:0] ry);
    BusWires = bus; Rx_data = rx; Ry_data = ry;
    Done = 1'b1; tick();
    Done = 1'b0; tick();
  endtask

  task automatic pop_one();
    Next = 1'b1; tick();
    Next = 1'b0;
  endtask

  task automatic do_clear();
    Clear = 1'b1; tick();
    Clear = 1'b0;
  endtask

  initial begin
    Resetn = 1'b0; Done = 1'b0; Enable = 1'b1; Next = 1'b0; Clear = 1'b0;
    BusWires = '0; Rx_data = '0; Ry_data = '0;
    #12;
    check_eq("rst_level", 32'(Level), 32'd0);
    check_eq("rst_empty", 32'(Empty), 32'd1);
    check_eq("rst_full", 32'(Full), 32'd0);
    check_eq("rst_valid", 32'(Out_valid), 32'd0);
    check_eq("rst_ovf", 32'(Overflow), 32'd0);
    check_eq("rst_out_bus", 32'(Out_bus), 32'd0);
    Resetn = 1'b1;
    tick();

    // Done held high for three cycles gives a single record
    BusWires = 16'h0008; Rx_data = 16'h0008; Ry_data = 16'h0003;
    Done = 1'b1; tick(); tick(); tick();
    Done = 1'b0; tick();
    check_eq("hold_level", 32'(Level), 32'd1);
    check_eq("hold_index", 32'(Out_index), 32'd0);
    check_eq("hold_bus", 32'(Out_bus), 32'h0008);
    check_eq("hold_rx", 32'(Out_rx), 32'h0008);
    check_eq("hold_ry", 32'(Out_ry), 32'h0003);

    // Reach Level 3, then assert reset between edges
    pulse(16'h1, 16'h2, 16'h3);
    pulse(16'h4, 16'h5, 16'h6);
    check_eq("pre_rst_level", 32'(Level), 32'd3);
    #2 Resetn = 1'b0;
    #1;
    check_eq("async_rst_level", 32'(Level), 32'd0);
    check_eq("async_rst_empty", 32'(Empty), 32'd1);
    check_eq("async_rst_valid", 32'(Out_valid), 32'd0);
    #1 Resetn = 1'b1;
    tick();

    // Nine pulses into an 8-deep FIFO
    for (int i = 0; i < 8; i++) pulse(16'(16'h20 + i), 16'(i), 16'(i + 1));
    check_eq("fill_full", 32'(Full), 32'd1);
    check_eq("fill_level", 32'(Level), 32'd8);
    check_eq("fill_ovf", 32'(Overflow), 32'd0);
    pulse(16'hDEAD, 16'h0, 16'h0);
    check_eq("drop_ovf", 32'(Overflow), 32'd1);
    check_eq("drop_level", 32'(Level), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_index", 32'(Out_index), 32'(i));
      check_eq("drain_bus", 32'(Out_bus), 32'(16'h20 + i));
      check_eq("drain_ry", 32'(Out_ry), 32'(i + 1));
      pop_one();
    end
    check_eq("drain_empty", 32'(Empty), 32'd1);
    check_eq("drain_out_zero", 32'(Out_index), 32'd0);
    check_eq("drain_ovf_sticky", 32'(Overflow), 32'd1);

    // Full FIFO with a push and a pop in the same cycle
    do_clear();
    check_eq("clr_ovf", 32'(Overflow), 32'd0);
    for (int i = 0; i < 8; i++) pulse(16'(16'h100 + i), 16'h0, 16'h0);
    BusWires = 16'h01FF; Done = 1'b1; Next = 1'b1; tick();
    Done = 1'b0; Next = 1'b0;
    check_eq("pp_level", 32'(Level), 32'd8);
    check_eq("pp_ovf", 32'(Overflow), 32'd0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      check_eq("pp_index", 32'(Out_index), 32'(i));
      pop_one();
    end
    check_eq("pp_empty", 32'(Empty), 32'd1);

    // Enable=0 captures only advance the index
    do_clear();
    Enable = 1'b0;
    pulse(16'h1, 16'h1, 16'h1);
    pulse(16'h2, 16'h2, 16'h2);
    check_eq("en0_level", 32'(Level), 32'd0);
    Enable = 1'b1;
    pulse(16'h3, 16'h3, 16'h3);
    check_eq("en1_level", 32'(Level), 32'd1);
    check_eq("en1_index", 32'(Out_index), 32'd2);
    check_eq("en0_no_ovf", 32'(Overflow), 32'd0);
    pop_one();
    check_eq("pop_to_empty", 32'(Empty), 32'd1);
    pop_one();
    check_eq("pop_on_empty_level", 32'(Level), 32'd0);
    check_eq("pop_on_empty_valid", 32'(Out_valid), 32'd0);
    // Push with Next while empty: the push wins
    BusWires = 16'h00AA; Done = 1'b1; Next = 1'b1; tick();
    Done = 1'b0; Next = 1'b0;
    check_eq("empty_pp_level", 32'(Level), 32'd1);
    check_eq("empty_pp_index", 32'(Out_index), 32'd3);
    check_eq("empty_pp_bus", 32'(Out_bus), 32'h00AA);
    tick();

    // Clear beats a simultaneous capture
    do_clear();
    for (int i = 0; i < 9; i++) pulse(16'(i), 16'h0, 16'h0);
    pop_one(); pop_one(); pop_one();
    check_eq("pre_clr_level", 32'(Level), 32'd5);
    check_eq("pre_clr_ovf", 32'(Overflow), 32'd1);
    check_eq("pre_clr_index", 32'(Out_index), 32'd3);
    Clear = 1'b1; Done = 1'b1; tick();
    Clear = 1'b0; Done = 1'b0;
    check_eq("clr_level", 32'(Level), 32'd0);
    check_eq("clr_ovf2", 32'(Overflow), 32'd0);
    check_eq("clr_empty", 32'(Empty), 32'd1);
    tick();
    pulse(16'h0055, 16'h0, 16'h0);
    check_eq("post_clr_level", 32'(Level), 32'd1);
    check_eq("post_clr_index", 32'(Out_index), 32'd0);
    check_eq("post_clr_bus", 32'(Out_bus), 32'h0055);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
